dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory wrapper between two requesters: the processor load/store stage (CPU port) and a peripheral/DMA master (EXT port).
- Grants at most one access per cycle and drives the wrapper's read enable, write enable, address, data, width and unsigned inputs.
- Tracks in-flight reads so each read result returns only to its issuer.
- CPU has fixed priority; a wait counter guarantees EXT forward progress.

Parameters:
- RD_LAT, 1, memory read latency in cycles from the enable cycle to valid rd_data (range 1-3)
- MAX_WAIT, 4, consecutive cycles EXT may be denied before it is forced to win the next conflict

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cpu_req  input  1  CPU access request; fields held stable until cpu_gnt
- cpu_we  input  1  1 = store, 0 = load
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data
- cpu_width  input  2  2'b10 byte, 2'b01 half, other values word
- cpu_unsigned  input  1  load extension select, passed through
- cpu_gnt  output  1  request accepted this cycle (combinational)
- cpu_stall  output  1  cpu_req & ~cpu_gnt
- cpu_rvalid  output  1  cpu_rdata valid
- cpu_rdata  output  32  load result
- ext_req, ext_we, ext_addr[31:0], ext_wdata[31:0], ext_width[2], ext_unsigned  input  same meaning as the CPU fields, for EXT
- ext_gnt  output  1  EXT request accepted this cycle
- ext_rvalid  output  1  ext_rdata valid
- ext_rdata  output  32  load result
- mem_rd_en  output  1  to wrapper rd_en
- mem_wrt_en  output  1  to wrapper wrt_en
- mem_addr  output  32  to wrapper wrt_addr
- mem_wrt_data  output  32  to wrapper wrt_data
- mem_width  output  2  to wrapper width
- mem_unsigned  output  1  to wrapper mem_unsigned
- mem_rd_data  input  32  from wrapper rd_data

Behaviour:
Reset
- rst is sampled on the rising edge of clk.
- On reset: state=CPU_PRI, wait_cnt=0, in-flight tag pipeline cleared.
- cpu_rvalid=0 and ext_rvalid=0 on the first cycle after reset.
- Reads in flight at reset are dropped and never reported.

State machine
- Two states: CPU_PRI (default) and EXT_FORCE.
- CPU_PRI: cpu_req wins; ext_gnt = ext_req & ~cpu_req.
- EXT_FORCE: ext_req wins; cpu_gnt = cpu_req & ~ext_req.
- wait_cnt increments on each cycle with ext_req & ~ext_gnt, saturating at MAX_WAIT.
- wait_cnt clears on ext_gnt or when ext_req=0.
- CPU_PRI -> EXT_FORCE when the next-cycle wait_cnt equals MAX_WAIT.
- EXT_FORCE -> CPU_PRI on ext_gnt, or when ext_req drops (request withdrawal is legal only before a grant).

Memory drive
- Memory outputs are combinational from the granted requester.
- mem_rd_en = gnt & ~we; mem_wrt_en = gnt & we.
- With no grant, both enables are 0. The other mem fields are don't-care but are driven from CPU inputs, so they never float.
- At most one grant per cycle; cpu_gnt & ext_gnt is never 1.

Read return
- Each granted read pushes an owner tag (valid, owner) into an RD_LAT-deep shift register.
- At tag exit: cpu_rvalid or ext_rvalid pulses for exactly 1 cycle.
- cpu_rdata and ext_rdata both equal mem_rd_data; consumers qualify with rvalid.
- Back-to-back reads from alternating owners return in issue order, one per cycle, with no bubble.

Writes
- Fire-and-forget: write acceptance is cpu_gnt/ext_gnt; no rvalid is generated.

Hazards
- Read-after-write to the same address from different owners returns the new data, because the memory serialises accesses.
- The arbiter performs no address comparison.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum arb_state_t {CPU_PRI, EXT_FORCE}
  - owner_t (1 bit: OWN_CPU=0, OWN_EXT=1)
  - width localparams W_BYTE=2'b10, W_HALF=2'b01, W_WORD=2'b00
  - struct mem_req_t {we, addr, wdata, width, unsigned}
- One sub-module, rd_tag_pipe: parameterised RD_LAT shift register of {valid, owner} with synchronous clear. The arbitration FSM stays in the top.

Test Plan:
- Reset mid-read: CPU read of 0x10 issued, rst asserted the next cycle -> no cpu_rvalid is ever produced; all enables are 0 during reset.
- CPU-only: store 0xDEADBEEF to 0x40 (word), then load 0x40 -> cpu_gnt on both same-cycle, cpu_stall=0, cpu_rvalid RD_LAT cycles after the load grant with cpu_rdata=0xDEADBEEF.
- Conflict, MAX_WAIT=4: cpu_req and ext_req held high for 8 cycles, both loads -> cpu_gnt cycles 0-3, ext_gnt cycle 4, cpu_gnt cycles 5+; cpu_stall=1 only in cycle 4.
- Alternating reads (CPU 0x0, EXT 0x4, CPU 0x8) with memory preloaded 1, 2, 3 -> rvalid sequence cpu, ext, cpu on consecutive cycles with data 1, 2, 3.
- Pass-through: EXT store byte (width=2'b10, wdata=0x123456AB) to 0x80 -> mem_wrt_en=1, mem_width=2'b10, mem_addr=0x80, mem_wrt_data=0x123456AB in the grant cycle.
- EXT withdrawal while in EXT_FORCE (ext_req drops before grant) -> state returns to CPU_PRI next cycle, wait_cnt=0, no spurious ext_gnt.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // CPU_PRI: the CPU wins conflicts. EXT_FORCE: EXT wins the next conflict.
  typedef enum logic {
    CPU_PRI   = 1'b0,
    EXT_FORCE = 1'b1
  } arb_state_t;

  // Identifies which requester issued a read.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  // Access width encodings as understood by the memory wrapper.
  localparam logic [1:0] W_BYTE = 2'b10;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b00;

  // One requester's access fields, bundled so the grant mux is one line.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        is_unsigned;
  } mem_req_t;

  // Entry of the in-flight read tracker.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Delay line of read owner tags; one entry enters per cycle and leaves
// RD_LAT cycles later, aligned with the memory's read data.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [RD_LAT];
  rd_tag_t pipe_d [RD_LAT];

  // Next-state of the shift register: new tag at the head, others advance.
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Shift register with synchronous clear; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (rst) begin
        pipe_q[i] <= '0;
      end else begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory wrapper.
// The CPU has fixed priority; a wait counter forces an EXT win after the
// EXT port has been denied MAX_WAIT consecutive cycles.
//
// Handshake: a requester raises *_req with its fields and holds them stable
// until *_gnt is seen high in the same cycle; the access is taken in that
// cycle. A read returns later as a one-cycle *_rvalid pulse with *_rdata.
// A request may be withdrawn only before it is granted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4,
  localparam int WCW     = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  // CPU port
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [1:0]       cpu_width,
  input  logic             cpu_unsigned,
  output logic             cpu_gnt,
  output logic             cpu_stall,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  // EXT port
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [31:0]      ext_wdata,
  input  logic [1:0]       ext_width,
  input  logic             ext_unsigned,
  output logic             ext_gnt,
  output logic             ext_rvalid,
  output logic [31:0]      ext_rdata,
  // Memory wrapper
  output logic             mem_rd_en,
  output logic             mem_wrt_en,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wrt_data,
  output logic [1:0]       mem_width,
  output logic             mem_unsigned,
  input  logic [31:0]      mem_rd_data,
  // Debug visibility of the arbitration FSM
  output arb_state_t       dbg_state,
  output logic [WCW-1:0]   dbg_wait_cnt
);

  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  arb_state_t     state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;

  mem_req_t cpu_fields, ext_fields, sel_fields;
  rd_tag_t  tag_in, tag_out;
  logic     any_gnt;

  assign cpu_fields = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata,
                        width: cpu_width, is_unsigned: cpu_unsigned};
  assign ext_fields = '{we: ext_we, addr: ext_addr, wdata: ext_wdata,
                        width: ext_width, is_unsigned: ext_unsigned};

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst) begin
      if (state_q == CPU_PRI) begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_req & ~cpu_req;
      end else begin
        ext_gnt = ext_req;
        cpu_gnt = cpu_req & ~ext_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign any_gnt   = cpu_gnt | ext_gnt;

  // Memory drive: fields follow the winner, defaulting to the CPU inputs.
  always_comb begin
    sel_fields   = ext_gnt ? ext_fields : cpu_fields;
    mem_rd_en    = any_gnt & ~sel_fields.we;
    mem_wrt_en   = any_gnt & sel_fields.we;
    mem_addr     = sel_fields.addr;
    mem_wrt_data = sel_fields.wdata;
    mem_width    = sel_fields.width;
    mem_unsigned = sel_fields.is_unsigned;
  end

  // Starvation counter and FSM next-state.
  always_comb begin
    wait_d  = wait_q;
    state_d = state_q;
    if (!ext_req || ext_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
    case (state_q)
      CPU_PRI: begin
        if (wait_d == WAIT_MAX) state_d = EXT_FORCE;
      end
      EXT_FORCE: begin
        if (ext_gnt || !ext_req) state_d = CPU_PRI;
      end
      default: state_d = CPU_PRI;
    endcase
  end

  // Arbitration FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CPU_PRI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_q;

  // Every granted read leaves a tag that emerges with its data.
  assign tag_in = '{valid: mem_rd_en, owner: (ext_gnt ? OWN_EXT : OWN_CPU)};

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Route the returning read to its issuer; masked during reset.
  assign cpu_rvalid = tag_out.valid & (tag_out.owner == OWN_CPU) & ~rst;
  assign ext_rvalid = tag_out.valid & (tag_out.owner == OWN_EXT) & ~rst;
  assign cpu_rdata  = mem_rd_data;
  assign ext_rdata  = mem_rd_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory model and a
// scoreboard that matches returned reads against expected owner/data/cycle.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        cpu_req = 0, cpu_we = 0, cpu_unsigned = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [1:0]  cpu_width = W_WORD;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ext_req = 0, ext_we = 0, ext_unsigned = 0;
  logic [31:0] ext_addr = 0, ext_wdata = 0;
  logic [1:0]  ext_width = W_WORD;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_rd_en, mem_wrt_en, mem_unsigned;
  logic [31:0] mem_addr, mem_wrt_data, mem_rd_data;
  logic [1:0]  mem_width;
  arb_state_t  dbg_state;
  logic [2:0]  dbg_wait_cnt;

  dmem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_width(cpu_width), .cpu_unsigned(cpu_unsigned),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_width(ext_width), .ext_unsigned(ext_unsigned),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_rd_en(mem_rd_en), .mem_wrt_en(mem_wrt_en), .mem_addr(mem_addr),
    .mem_wrt_data(mem_wrt_data), .mem_width(mem_width),
    .mem_unsigned(mem_unsigned), .mem_rd_data(mem_rd_data),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [256];
  logic [31:0] rd_pipe [RD_LAT];
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_wrt_en) begin
      if (mem_width == W_BYTE)
        mem_arr[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wrt_data[7:0];
      else if (mem_width == W_HALF)
        mem_arr[mem_addr[9:2]][16*mem_addr[1] +: 16] <= mem_wrt_data[15:0];
      else
        mem_arr[mem_addr[9:2]] <= mem_wrt_data;
    end
    rd_pipe[0] <= mem_rd_en ? mem_arr[mem_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // {owner, data}
  int          due_q[$];   // cycle in which rvalid must appear

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the sampling point of a read-grant cycle.
  task automatic expect_read(input logic owner, input logic [31:0] data);
    exp_q.push_back({owner, data});
    due_q.push_back(cyc + RD_LAT);
  endtask

  // Monitor: every rvalid must match the oldest expected read, on time.
  always @(negedge clk) begin
    logic [32:0] e;
    int          d;
    if (cpu_rvalid && ext_rvalid) begin
      checks++; failures++;
      $display("FAIL both_rvalid: cpu_rvalid=1 ext_rvalid=1 expected at most one (cycle %0d)", cyc);
    end else if (cpu_rvalid || ext_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid: cpu=%0b ext=%0b expected none (cycle %0d)",
                 cpu_rvalid, ext_rvalid, cyc);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if ((ext_rvalid !== e[32]) || ((ext_rvalid ? ext_rdata : cpu_rdata) !== e[31:0]) || (d != cyc)) begin
          failures++;
          $display("FAIL read_return: owner=%0b data=0x%08h cycle=%0d expected owner=%0b data=0x%08h cycle=%0d",
                   ext_rvalid, (ext_rvalid ? ext_rdata : cpu_rdata), cyc, e[32], e[31:0], d);
        end
      end
    end else if (due_q.size() > 0 && due_q[0] < cyc) begin
      checks++; failures++;
      e = exp_q.pop_front();
      d = due_q.pop_front();
      $display("FAIL missing_rvalid: got none expected owner=%0b data=0x%08h at cycle %0d",
               e[32], e[31:0], d);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; ext_req = 0; ext_we = 0;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cpu_width = W_WORD; cpu_unsigned = 0;
  endtask

  task automatic ext_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] width, input logic uns);
    ext_req = 1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    ext_width = width; ext_unsigned = uns;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h5A5A_0000 | (i << 2);
    mem_arr[0] = 32'd1; mem_arr[1] = 32'd2; mem_arr[2] = 32'd3;

    // Reset state
    rst = 1;
    repeat (3) step();
    sample();
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wrt_en", mem_wrt_en, 0);
    step(); rst = 0;
    sample();
    chk("post_rst_cpu_rvalid", cpu_rvalid, 0);
    chk("post_rst_ext_rvalid", ext_rvalid, 0);
    chk("post_rst_state", dbg_state, CPU_PRI);
    chk("post_rst_wait", dbg_wait_cnt, 0);

    // Reset mid-read: the in-flight CPU read must never be reported
    step(); cpu_drive(0, 32'h10, 0);
    sample();
    chk("midrd_gnt", cpu_gnt, 1);
    chk("midrd_rd_en", mem_rd_en, 1);
    step(); rst = 1; ext_drive(0, 32'h14, 0, W_WORD, 0);
    sample();
    chk("midrd_rst_cpu_gnt", cpu_gnt, 0);
    chk("midrd_rst_ext_gnt", ext_gnt, 0);
    chk("midrd_rst_rd_en", mem_rd_en, 0);
    chk("midrd_rst_wrt_en", mem_wrt_en, 0);
    chk("midrd_rst_rvalid", cpu_rvalid, 0);
    step(); rst = 0; idle();
    repeat (4) step();

    // CPU-only store then load
    cpu_drive(1, 32'h40, 32'hDEADBEEF);
    sample();
    chk("st_gnt", cpu_gnt, 1);
    chk("st_stall", cpu_stall, 0);
    chk("st_wrt_en", mem_wrt_en, 1);
    chk("st_rd_en", mem_rd_en, 0);
    chk("st_addr", mem_addr, 32'h40);
    chk("st_wdata", mem_wrt_data, 32'hDEADBEEF);
    step(); cpu_drive(0, 32'h40, 0);
    sample();
    chk("ld_gnt", cpu_gnt, 1);
    chk("ld_stall", cpu_stall, 0);
    chk("ld_rd_en", mem_rd_en, 1);
    expect_read(OWN_CPU, 32'hDEADBEEF);
    step(); idle();
    repeat (3) step();

    // Conflict: both load for 8 cycles; EXT forced through in cycle 4
    cpu_drive(0, 32'h40, 0);
    ext_drive(0, 32'h44, 0, W_WORD, 0);
    for (int k = 0; k < 8; k++) begin
      sample();
      chk($sformatf("conf_cpu_gnt_%0d", k), cpu_gnt, (k != 4));
      chk($sformatf("conf_ext_gnt_%0d", k), ext_gnt, (k == 4));
      chk($sformatf("conf_stall_%0d", k), cpu_stall, (k == 4));
      if (k == 4) begin
        chk("conf_state_force", dbg_state, EXT_FORCE);
        expect_read(OWN_EXT, 32'h5A5A_0044);
      end else begin
        expect_read(OWN_CPU, 32'hDEADBEEF);
      end
      step();
    end
    idle();
    repeat (3) step();

    // Alternating owners, back-to-back reads, no bubble
    cpu_drive(0, 32'h0, 0);
    sample(); chk("alt0_gnt", cpu_gnt, 1); expect_read(OWN_CPU, 32'd1);
    step(); cpu_req = 0; ext_drive(0, 32'h4, 0, W_WORD, 0);
    sample(); chk("alt1_gnt", ext_gnt, 1); expect_read(OWN_EXT, 32'd2);
    step(); ext_req = 0; cpu_drive(0, 32'h8, 0);
    sample(); chk("alt2_gnt", cpu_gnt, 1); expect_read(OWN_CPU, 32'd3);
    step(); idle();
    repeat (3) step();

    // EXT byte store pass-through; CPU fields hold different values
    cpu_addr = 32'hFFFF_0000; cpu_wdata = 32'h0; cpu_width = W_WORD; cpu_unsigned = 0;
    ext_drive(1, 32'h80, 32'h123456AB, W_BYTE, 1);
    sample();
    chk("pt_ext_gnt", ext_gnt, 1);
    chk("pt_wrt_en", mem_wrt_en, 1);
    chk("pt_rd_en", mem_rd_en, 0);
    chk("pt_width", mem_width, W_BYTE);
    chk("pt_addr", mem_addr, 32'h80);
    chk("pt_wdata", mem_wrt_data, 32'h123456AB);
    chk("pt_unsigned", mem_unsigned, 1);
    step(); idle();
    repeat (2) step();

    // Read-after-write across owners returns the new data
    cpu_drive(1, 32'h48, 32'hCAFEF00D);
    sample(); chk("raw_st_gnt", cpu_gnt, 1);
    step(); cpu_req = 0; ext_drive(0, 32'h48, 0, W_WORD, 0);
    sample(); chk("raw_ld_gnt", ext_gnt, 1); expect_read(OWN_EXT, 32'hCAFEF00D);
    step(); idle();
    repeat (3) step();

    // EXT withdrawal while in EXT_FORCE
    cpu_drive(1, 32'h100, 32'h0000_0077);
    ext_drive(0, 32'h104, 0, W_WORD, 0);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("wd_cpu_gnt_%0d", k), cpu_gnt, 1);
      chk($sformatf("wd_wait_%0d", k), dbg_wait_cnt, k);
      step();
    end
    ext_req = 0;
    sample();
    chk("wd_state_force", dbg_state, EXT_FORCE);
    chk("wd_ext_gnt", ext_gnt, 0);
    chk("wd_cpu_gnt_force", cpu_gnt, 1);
    step(); cpu_req = 0;
    sample();
    chk("wd_state_back", dbg_state, CPU_PRI);
    chk("wd_wait_clear", dbg_wait_cnt, 0);
    chk("wd_no_ext_gnt", ext_gnt, 0);
    step();

    // Drain and confirm every expected read was returned
    repeat (RD_LAT + 3) step();
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
